counter_sweep_ctrl: RTL and testbench
=====================================

COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, width of count, lo, hi.
REQ-002 Parameter: CYC_W, 4, width of cycles.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  begin a sweep; sampled only in IDLE.
REQ-006 stop  input  1  abort an active sweep.
REQ-007 pause  input  1  freeze count and state while high.
REQ-008 lo  input  WIDTH  lower sweep limit, latched on accepted start.
REQ-009 hi  input  WIDTH  upper sweep limit, latched on accepted start.
REQ-010 cycles  input  CYC_W  number of lo->hi->lo triangles, latched on accepted start.
REQ-011 count  output  WIDTH  current counter value.
REQ-012 dir  output  1  1 while counting up (state UP), else 0.
REQ-013 busy  output  1  1 in UP or DOWN.
REQ-014 done  output  1  one-cycle pulse on normal completion.
REQ-015 err  output  1  one-cycle pulse on rejected start.

Function
REQ-016 FSM states SHALL be IDLE, UP, DOWN, DONE, ERR; all outputs registered.
REQ-017 IDLE: start=1 with lo<hi and cycles!=0 SHALL latch lo/hi/cycles, load count<=lo, and enter UP next cycle.
REQ-018 IDLE: start=1 with lo>=hi or cycles==0 SHALL enter ERR; count unchanged.
REQ-019 UP: count!=hi SHALL increment count by 1; count==hi SHALL decrement count by 1 and enter DOWN.
REQ-020 DOWN: count!=lo SHALL decrement count by 1; count==lo with remaining>1 SHALL decrement remaining, set count<=lo+1, enter UP.
REQ-021 DOWN: count==lo with remaining==1 SHALL hold count at lo and enter DONE.
REQ-022 DONE and ERR SHALL last exactly one cycle (done/err=1 respectively), then return to IDLE.
REQ-023 busy SHALL be high for exactly 2*(hi-lo)*cycles+1 cycles per uninterrupted sweep; done SHALL assert the cycle after busy falls.
REQ-024 pause=1 in UP/DOWN SHALL hold count, state, remaining; pause ignored in IDLE/DONE/ERR.
REQ-025 stop=1 in UP/DOWN SHALL enter IDLE next cycle, holding count, no done pulse; stop ignored elsewhere.
REQ-026 Priority SHALL be rst > stop > pause > normal step.
REQ-027 start while busy SHALL be ignored; changes to lo/hi/cycles mid-sweep SHALL have no effect.
REQ-028 Count arithmetic SHALL be WIDTH-bit unsigned; wrap-around cannot occur since lo<hi is enforced.
REQ-029 lo=0, hi=2^WIDTH-1 SHALL sweep full range without wrap.

Reset
REQ-030 rst=1 SHALL on the next edge force state=IDLE, count=0, dir=0, busy=0, done=0, err=0, remaining=0, latched limits=0.
REQ-031 rst mid-sweep SHALL abort immediately with no done pulse; rst overrides start in the same cycle.

Structure
REQ-032 State encodings and default WIDTH/CYC_W SHALL live in a shared include package sweep_pkg.
REQ-033 Count register SHALL be a sub-module updown_counter_ld (sync active-high rst, enable, direction, load, load value), sequenced by the FSM.

Verification
REQ-034 lo=2, hi=4, cycles=1, start pulse -> count 2,3,4,3,2 with busy=1 for 5 cycles, dir 1,1,1,0,0, then done=1 one cycle.
REQ-035 lo=2, hi=4, cycles=2 -> count 2,3,4,3,2,3,4,3,2, busy 9 cycles, single done pulse.
REQ-036 lo=5, hi=5, cycles=3, start -> err=1 one cycle, busy never high, count unchanged; same for cycles=0.
REQ-037 lo=0, hi=10, cycles=1, pause high 3 cycles at count=4 -> count holds 4 for 3 cycles, total busy 24 cycles.
REQ-038 lo=0, hi=10, stop at count=7 -> IDLE next cycle, count stays 7, done never asserts; new start accepted next cycle.
REQ-039 rst asserted at count=6 during DOWN, with start high same cycle -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared definitions for the counter sweep controller: default widths and FSM state encoding.
package sweep_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CYC_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    UP,
    DOWN,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/updown_counter_ld.sv
// Loadable up/down counter; load takes precedence over count enable.
module updown_counter_ld
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (ld) begin
      count_d = ld_val;
    end else if (en) begin
      count_d = up ? count_q + 1'b1 : count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Triangle sweep controller: counts lo->hi->lo for a latched number of cycles.
module counter_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CYC_W = CYC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [CYC_W-1:0] cycles,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [CYC_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             cnt_en;
  logic             cnt_up;
  logic             cnt_ld;
  logic [WIDTH-1:0] cnt_ld_val;

  updown_counter_ld #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .up    (cnt_up),
    .ld    (cnt_ld),
    .ld_val(cnt_ld_val),
    .count (count)
  );

  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    rem_d      = rem_q;
    cnt_en     = 1'b0;
    cnt_up     = 1'b0;
    cnt_ld     = 1'b0;
    cnt_ld_val = lo_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ((lo < hi) && (cycles != '0)) begin
            lo_d       = lo;
            hi_d       = hi;
            rem_d      = cycles;
            cnt_ld     = 1'b1;
            cnt_ld_val = lo;
            state_d    = UP;
          end else begin
            state_d = ERR;
          end
        end
      end
      UP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!pause) begin
          cnt_en = 1'b1;
          if (count != hi_q) begin
            cnt_up = 1'b1;
          end else begin
            state_d = DOWN;
          end
        end
      end
      DOWN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!pause) begin
          if (count != lo_q) begin
            cnt_en = 1'b1;
          end else if (rem_q > CYC_W'(1)) begin
            // Turnaround at lo skips a repeated lo so each triangle spans 2*(hi-lo) steps.
            rem_d      = rem_q - 1'b1;
            cnt_ld     = 1'b1;
            cnt_ld_val = lo_q + 1'b1;
            state_d    = UP;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    dir_d  = (state_d == UP);
    busy_d = (state_d == UP) || (state_d == DOWN);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign dir  = dir_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl with hand-computed expected sequences.
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause;
  logic [7:0] lo, hi;
  logic [3:0] cycles;
  logic [7:0] count;
  logic       dir, busy, done, err;

  int n_checks = 0;
  int n_fails  = 0;

  int exp34_cnt [5] = '{2, 3, 4, 3, 2};
  int exp34_dir [5] = '{1, 1, 1, 0, 0};
  int exp35_cnt [9] = '{2, 3, 4, 3, 2, 3, 4, 3, 2};

  always #5 clk = ~clk;

  counter_sweep_ctrl #(
    .WIDTH(8),
    .CYC_W(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .pause (pause),
    .lo    (lo),
    .hi    (hi),
    .cycles(cycles),
    .count (count),
    .dir   (dir),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int dones;
    int mx;

    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    lo = '0; hi = '0; cycles = '0;
    step();
    step();
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    step();

    // lo=2 hi=4 cycles=1
    lo = 8'd2; hi = 8'd4; cycles = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("s1_count", 32'(count), 32'(exp34_cnt[i]));
      chk("s1_dir", 32'(dir), 32'(exp34_dir[i]));
      chk("s1_busy", 32'(busy), 1);
      chk("s1_done_low", 32'(done), 0);
      step();
    end
    chk("s1_done", 32'(done), 1);
    chk("s1_busy_fall", 32'(busy), 0);
    chk("s1_count_end", 32'(count), 2);
    step();
    chk("s1_done_once", 32'(done), 0);

    // lo=2 hi=4 cycles=2, with start and limit changes mid-sweep
    lo = 8'd2; hi = 8'd4; cycles = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 2) begin start = 1'b1; lo = 8'd0; hi = 8'd9; cycles = 4'd5; end
      if (i == 4) start = 1'b0;
      chk("s2_count", 32'(count), 32'(exp35_cnt[i]));
      chk("s2_busy", 32'(busy), 1);
      if (done) dones++;
      step();
    end
    chk("s2_done", 32'(done), 1);
    chk("s2_busy_fall", 32'(busy), 0);
    if (done) dones++;
    step();
    if (done) dones++;
    chk("s2_done_pulses", 32'(dones), 1);

    // rejected starts: lo==hi, then cycles==0
    lo = 8'd5; hi = 8'd5; cycles = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    chk("e1_err", 32'(err), 1);
    chk("e1_busy", 32'(busy), 0);
    chk("e1_count", 32'(count), 2);
    step();
    chk("e1_err_once", 32'(err), 0);
    chk("e1_busy_after", 32'(busy), 0);
    lo = 8'd1; hi = 8'd3; cycles = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("e2_err", 32'(err), 1);
    chk("e2_busy", 32'(busy), 0);
    chk("e2_count", 32'(count), 2);
    step();
    chk("e2_err_once", 32'(err), 0);

    // pause for 3 cycles at count=4
    lo = 8'd0; hi = 8'd10; cycles = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (busy) n++;
    end
    chk("p_count_at4", 32'(count), 4);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (busy) n++;
      chk("p_hold", 32'(count), 4);
      chk("p_dir", 32'(dir), 1);
    end
    pause = 1'b0;
    for (int i = 0; i < 60 && busy; i++) begin
      step();
      if (busy) n++;
    end
    chk("p_busy_total", 32'(n), 24);
    chk("p_done", 32'(done), 1);
    chk("p_count_end", 32'(count), 0);
    step();

    // stop at count=7, then immediate restart
    lo = 8'd0; hi = 8'd10; cycles = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("st_count7", 32'(count), 7);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("st_busy", 32'(busy), 0);
    chk("st_count_hold", 32'(count), 7);
    chk("st_done", 32'(done), 0);
    chk("st_dir", 32'(dir), 0);
    lo = 8'd3; hi = 8'd5; cycles = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk("st_restart_busy", 32'(busy), 1);
    chk("st_restart_count", 32'(count), 3);
    for (int i = 0; i < 5; i++) step();
    chk("st_restart_done", 32'(done), 1);
    step();

    // reset during DOWN at count=6 with start high
    lo = 8'd0; hi = 8'd10; cycles = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("r_count6", 32'(count), 6);
    chk("r_dir_down", 32'(dir), 0);
    chk("r_busy_pre", 32'(busy), 1);
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk("r_count", 32'(count), 0);
    chk("r_busy", 32'(busy), 0);
    chk("r_dir", 32'(dir), 0);
    chk("r_done", 32'(done), 0);
    chk("r_err", 32'(err), 0);
    step();
    chk("r_idle_busy", 32'(busy), 0);
    chk("r_idle_done", 32'(done), 0);

    // full range sweep
    lo = 8'd0; hi = 8'd255; cycles = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    mx = 0;
    for (int i = 0; i < 600 && busy; i++) begin
      if (int'(count) > mx) mx = int'(count);
      step();
      if (busy) n++;
    end
    chk("f_busy_total", 32'(n), 511);
    chk("f_max", 32'(mx), 255);
    chk("f_done", 32'(done), 1);
    chk("f_count_end", 32'(count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
